// File: rtl/nibble_bist_pkg.sv
// Shared types and helpers for the nibble-adder BIST initiator/checker.
package nibble_bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int NUM_OPS = 256;

  function automatic logic [3:0] exp_sum(input logic [7:0] op);
    return op[7:4] + op[3:0];
  endfunction

endpackage

// File: rtl/nibble_bist_delay.sv
// LATENCY-deep shift register carrying {valid, operand, expected sum} toward the compare point.
module nibble_bist_delay #(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_valid,
  input  logic [7:0] push_op,
  input  logic [3:0] push_exp,
  output logic       tail_valid,
  output logic [7:0] tail_op,
  output logic [3:0] tail_exp
);

  logic [LATENCY-1:0] valid_q;
  logic [7:0]         op_q  [LATENCY];
  logic [3:0]         exp_q [LATENCY];

  // Only the valid bits need resetting; stale payload behind a cleared valid is never compared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= push_valid;
      for (int i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    op_q[0]  <= push_op;
    exp_q[0] <= push_exp;
    for (int i = 1; i < LATENCY; i++) begin
      op_q[i]  <= op_q[i-1];
      exp_q[i] <= exp_q[i-1];
    end
  end

  assign tail_valid = valid_q[LATENCY-1];
  assign tail_op    = op_q[LATENCY-1];
  assign tail_exp   = exp_q[LATENCY-1];

endmodule

// File: rtl/nibble_add_bist.sv
// Sweeps all 256 operand pairs into the nibble adder and checks each returned sum.
module nibble_add_bist
  import nibble_bist_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [7:0]       op_out,
  input  logic [3:0]       res_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       first_fail_op
);

  state_t     state;
  logic       start_q;
  logic [2:0] drain_cnt;
  logic       tail_valid;
  logic [7:0] tail_op;
  logic [3:0] tail_exp;
  logic       accept;
  logic       mismatch;

  nibble_bist_delay #(.LATENCY(LATENCY)) u_delay (
    .clk        (clk),
    .reset      (reset),
    .push_valid (state == RUN),
    .push_op    (op_out),
    .push_exp   (exp_sum(op_out)),
    .tail_valid (tail_valid),
    .tail_op    (tail_op),
    .tail_exp   (tail_exp)
  );

  // Rising-edge qualified so a held start launches at most one sweep.
  assign accept   = start && !start_q && (state == IDLE || state == DONE);
  assign mismatch = tail_valid && (res_in != tail_exp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      start_q       <= 1'b0;
      drain_cnt     <= '0;
      op_out        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_fail_op <= '0;
    end else begin
      start_q <= start;
      if (mismatch) begin
        if (!(&err_count)) err_count <= err_count + 1'b1;
        if (err_count == '0) first_fail_op <= tail_op;
      end
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state         <= RUN;
            op_out        <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_fail_op <= '0;
          end
        end
        RUN: begin
          // op_out doubles as the operand counter; its wrap back to 0 is the DRAIN value too.
          op_out <= op_out + 8'd1;
          if (op_out == 8'(NUM_OPS - 1)) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 3'd1;
          if (drain_cnt == 3'(LATENCY - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_bist.sv
// Directed bench: three BIST instances against behavioural adder models with injectable faults.
module tb_nibble_add_bist;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  int         mode = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         busyMain, busyL2;

  logic [7:0] op_out, l2Op, e4Op;
  logic [3:0] res_in, l2Res, e4Res;
  logic       busy, done, pass, l2Busy, l2Done, l2Pass, e4Busy, e4Done, e4Pass;
  logic [7:0] err_count, first_fail_op, l2Err, l2First, e4First;
  logic [3:0] e4Err;

  logic [3:0] m1 = '0, m2 = '0, l2m1 = '0, l2m2 = '0, e4m1 = '0;

  always #5 clk = ~clk;

  nibble_add_bist #(.LATENCY(1), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op_out(op_out), .res_in(res_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_fail_op(first_fail_op)
  );

  nibble_add_bist #(.LATENCY(2), .ERR_W(8)) dutL2 (
    .clk(clk), .reset(reset), .start(start), .op_out(l2Op), .res_in(l2Res),
    .busy(l2Busy), .done(l2Done), .pass(l2Pass), .err_count(l2Err), .first_fail_op(l2First)
  );

  nibble_add_bist #(.LATENCY(1), .ERR_W(4)) dutE4 (
    .clk(clk), .reset(reset), .start(start), .op_out(e4Op), .res_in(e4Res),
    .busy(e4Busy), .done(e4Done), .pass(e4Pass), .err_count(e4Err), .first_fail_op(e4First)
  );

  // Adder models: mode 0 ideal 1-cycle, mode 1 bit0 stuck at 0, mode 2 two-cycle latency.
  always @(posedge clk) begin
    m1   <= op_out[7:4] + op_out[3:0];
    m2   <= m1;
    l2m1 <= l2Op[7:4] + l2Op[3:0];
    l2m2 <= l2m1;
    e4m1 <= e4Op[7:4] + e4Op[3:0];
  end

  assign res_in = (mode == 2) ? m2 : (mode == 1) ? {m1[3:1], 1'b0} : m1;
  assign l2Res  = l2m2;
  assign e4Res  = {e4m1[3:1], 1'b0};

  task automatic checkOutput(input string tag, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one sweep, optionally re-pulsing start when op_out reaches pulseAt.
  task automatic applyStimulus(input int pulseAt, output int bMain, output int bL2);
    pulseStart();
    checkOutput("start_done_low", done, 0);
    bMain = 0;
    bL2 = 0;
    for (int c = 0; c < 400; c++) begin
      if (busy) bMain++;
      if (l2Busy) bL2++;
      start = (pulseAt >= 0 && busy && op_out == pulseAt[7:0]);
      if (!busy && !l2Busy && !e4Busy) break;
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("sweep_finished", int'(busy | l2Busy | e4Busy), 0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_op_out", op_out, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_err", err_count, 0);
    checkOutput("rst_first", first_fail_op, 0);
    reset = 1'b0;

    // Ideal adder; also exercises LATENCY=2 and the 4-bit saturating counter.
    mode = 0;
    applyStimulus(-1, busyMain, busyL2);
    checkOutput("ideal_busy_cycles", busyMain, 257);
    checkOutput("ideal_done", done, 1);
    checkOutput("ideal_pass", pass, 1);
    checkOutput("ideal_err", err_count, 0);
    checkOutput("ideal_first", first_fail_op, 0);
    checkOutput("l2_busy_cycles", busyL2, 258);
    checkOutput("l2_pass", l2Pass, 1);
    checkOutput("l2_err", l2Err, 0);
    checkOutput("e4_err_saturated", e4Err, 15);
    checkOutput("e4_pass", e4Pass, 0);
    checkOutput("e4_done", e4Done, 1);

    mode = 1;
    applyStimulus(-1, busyMain, busyL2);
    checkOutput("stuck_err", err_count, 128);
    checkOutput("stuck_first", first_fail_op, 8'h01);
    checkOutput("stuck_pass", pass, 0);

    mode = 2;
    applyStimulus(-1, busyMain, busyL2);
    checkOutput("lat2_err", err_count, 255);
    checkOutput("lat2_first", first_fail_op, 8'h01);
    checkOutput("lat2_pass", pass, 0);

    mode = 0;
    applyStimulus(8'h10, busyMain, busyL2);
    checkOutput("midstart_busy_cycles", busyMain, 257);
    checkOutput("midstart_pass", pass, 1);
    checkOutput("midstart_err", err_count, 0);

    // Abort at operand 0x40 with an asynchronous reset.
    pulseStart();
    for (int c = 0; c < 300 && op_out != 8'h40; c++) @(negedge clk);
    checkOutput("abort_reached_40", op_out, 8'h40);
    reset = 1'b1;
    #1;
    checkOutput("abort_op_out", op_out, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_pass", pass, 0);
    checkOutput("abort_err", err_count, 0);
    checkOutput("abort_first", first_fail_op, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(-1, busyMain, busyL2);
    checkOutput("rerun_busy_cycles", busyMain, 257);
    checkOutput("rerun_done", done, 1);
    checkOutput("rerun_pass", pass, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
